// File: rtl/bsg_axil_store_unpacker.sv
// Replays packed {write_not_read, addr, data} command words as single AXI-lite
// master transactions, one at a time, and returns the addressed read lane.
module bsg_axil_store_unpacker #(
  parameter int axil_addr_width_p    = 32,
  parameter int axil_data_width_p    = 32,
  parameter int payload_data_width_p = 8
) (
  input  logic                             clk_i,
  input  logic                             reset_i,

  input  logic [axil_data_width_p-1:0]     data_i,
  input  logic                             v_i,
  output logic                             ready_o,

  output logic [axil_data_width_p-1:0]     data_o,
  output logic                             v_o,
  input  logic                             ready_i,

  output logic [axil_addr_width_p-1:0]     m_axil_awaddr_o,
  output logic [2:0]                       m_axil_awprot_o,
  output logic                             m_axil_awvalid_o,
  input  logic                             m_axil_awready_i,

  output logic [axil_data_width_p-1:0]     m_axil_wdata_o,
  output logic [axil_data_width_p/8-1:0]   m_axil_wstrb_o,
  output logic                             m_axil_wvalid_o,
  input  logic                             m_axil_wready_i,

  input  logic [1:0]                       m_axil_bresp_i,
  input  logic                             m_axil_bvalid_i,
  output logic                             m_axil_bready_o,

  output logic [axil_addr_width_p-1:0]     m_axil_araddr_o,
  output logic [2:0]                       m_axil_arprot_o,
  output logic                             m_axil_arvalid_o,
  input  logic                             m_axil_arready_i,

  input  logic [axil_data_width_p-1:0]     m_axil_rdata_i,
  input  logic [1:0]                       m_axil_rresp_i,
  input  logic                             m_axil_rvalid_i,
  output logic                             m_axil_rready_o,

  output logic                             error_o
);

  localparam int payload_addr_width_lp = axil_data_width_p - payload_data_width_p - 1;
  localparam int lanes_lp              = axil_data_width_p / payload_data_width_p;
  localparam int strb_width_lp         = axil_data_width_p / 8;
  localparam int lane_bytes_lp         = payload_data_width_p / 8;
  localparam int lg_lanes_lp           = $clog2(lanes_lp);
  localparam int lane_lsb_lp           = $clog2(lane_bytes_lp);
  localparam int lane_width_lp         = (lg_lanes_lp == 0) ? 1 : lg_lanes_lp;

  typedef enum logic [2:0] {
    e_ready,
    e_write,
    e_write_resp,
    e_read_req,
    e_read_resp,
    e_read_data
  } state_e;

  state_e                              state_q, state_d;
  logic                                aw_sent_q, aw_sent_d;
  logic                                w_sent_q, w_sent_d;
  logic                                error_q, error_d;
  // The direction bit is consumed by the accept-cycle state decision only.
  logic [axil_data_width_p-2:0]        cmd_q, cmd_d;
  logic [axil_data_width_p-1:0]        resp_q, resp_d;

  logic [payload_addr_width_lp-1:0]    payload_addr;
  logic [payload_data_width_p-1:0]     payload;
  logic [axil_addr_width_p-1:0]        axil_addr;
  logic [lane_width_lp-1:0]            lane;
  logic [strb_width_lp-1:0]            strb_base;
  logic [payload_data_width_p-1:0]     rdata_lane;
  logic                                aw_done, w_done;

  assign payload_addr = cmd_q[axil_data_width_p-2 -: payload_addr_width_lp];
  assign payload      = cmd_q[payload_data_width_p-1:0];
  assign axil_addr    = axil_addr_width_p'(payload_addr);

  if (lanes_lp == 1) begin : g_one_lane
    assign lane = '0;
  end else begin : g_lanes
    assign lane = payload_addr[lane_lsb_lp +: lg_lanes_lp];
  end

  assign strb_base  = strb_width_lp'({lane_bytes_lp{1'b1}});
  assign rdata_lane = m_axil_rdata_i[int'(lane)*payload_data_width_p +: payload_data_width_p];

  assign m_axil_awaddr_o = axil_addr;
  assign m_axil_araddr_o = axil_addr;
  assign m_axil_awprot_o = 3'b000;
  assign m_axil_arprot_o = 3'b000;
  assign m_axil_wdata_o  = {lanes_lp{payload}};
  assign m_axil_wstrb_o  = strb_base << (int'(lane) * lane_bytes_lp);
  assign data_o          = resp_q;
  assign error_o         = error_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= e_ready;
      aw_sent_q <= 1'b0;
      w_sent_q  <= 1'b0;
      error_q   <= 1'b0;
      cmd_q     <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      aw_sent_q <= aw_sent_d;
      w_sent_q  <= w_sent_d;
      error_q   <= error_d;
      cmd_q     <= cmd_d;
      resp_q    <= resp_d;
    end
  end

  // Every valid/ready pair transfers on the cycle both are high at the rising
  // edge; a valid, once raised, holds with stable payload until that cycle.
  always_comb begin
    state_d          = state_q;
    aw_sent_d        = aw_sent_q;
    w_sent_d         = w_sent_q;
    error_d          = error_q;
    cmd_d            = cmd_q;
    resp_d           = resp_q;
    ready_o          = 1'b0;
    v_o              = 1'b0;
    m_axil_awvalid_o = 1'b0;
    m_axil_wvalid_o  = 1'b0;
    m_axil_bready_o  = 1'b0;
    m_axil_arvalid_o = 1'b0;
    m_axil_rready_o  = 1'b0;
    aw_done          = aw_sent_q | m_axil_awready_i;
    w_done           = w_sent_q | m_axil_wready_i;

    case (state_q)
      e_ready: begin
        ready_o = 1'b1;
        if (v_i) begin
          cmd_d   = data_i[axil_data_width_p-2:0];
          state_d = data_i[axil_data_width_p-1] ? e_write : e_read_req;
        end
      end
      e_write: begin
        m_axil_awvalid_o = ~aw_sent_q;
        m_axil_wvalid_o  = ~w_sent_q;
        aw_sent_d        = aw_done;
        w_sent_d         = w_done;
        if (aw_done && w_done) state_d = e_write_resp;
      end
      e_write_resp: begin
        m_axil_bready_o = 1'b1;
        if (m_axil_bvalid_i) begin
          error_d   = error_q | (m_axil_bresp_i != 2'b00);
          aw_sent_d = 1'b0;
          w_sent_d  = 1'b0;
          state_d   = e_ready;
        end
      end
      e_read_req: begin
        m_axil_arvalid_o = 1'b1;
        if (m_axil_arready_i) state_d = e_read_resp;
      end
      e_read_resp: begin
        m_axil_rready_o = 1'b1;
        if (m_axil_rvalid_i) begin
          resp_d  = axil_data_width_p'(rdata_lane);
          error_d = error_q | (m_axil_rresp_i != 2'b00);
          state_d = e_read_data;
        end
      end
      e_read_data: begin
        v_o = 1'b1;
        if (ready_i) state_d = e_ready;
      end
      default: state_d = e_ready;
    endcase
  end

endmodule

// File: tb/tb_bsg_axil_store_unpacker.sv
// Directed bench for bsg_axil_store_unpacker: per-scenario tasks drive a
// hand-timed AXI-lite slave and compare against hand-computed values.
module tb_bsg_axil_store_unpacker;

  logic        clk;
  logic        reset_i;
  logic [31:0] data_i;
  logic        v_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic        v_o;
  logic        ready_i;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        error_o;

  int n_cmp = 0;
  int n_err = 0;

  // Handshake tallies; tests use deltas across a scenario.
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, vo_hi_cnt = 0;

  logic [31:0] exp_q[$];

  bsg_axil_store_unpacker #(
    .axil_addr_width_p(32),
    .axil_data_width_p(32),
    .payload_data_width_p(8)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .data_i(data_i),
    .v_i(v_i),
    .ready_o(ready_o),
    .data_o(data_o),
    .v_o(v_o),
    .ready_i(ready_i),
    .m_axil_awaddr_o(awaddr),
    .m_axil_awprot_o(awprot),
    .m_axil_awvalid_o(awvalid),
    .m_axil_awready_i(awready),
    .m_axil_wdata_o(wdata),
    .m_axil_wstrb_o(wstrb),
    .m_axil_wvalid_o(wvalid),
    .m_axil_wready_i(wready),
    .m_axil_bresp_i(bresp),
    .m_axil_bvalid_i(bvalid),
    .m_axil_bready_o(bready),
    .m_axil_araddr_o(araddr),
    .m_axil_arprot_o(arprot),
    .m_axil_arvalid_o(arvalid),
    .m_axil_arready_i(arready),
    .m_axil_rdata_i(rdata),
    .m_axil_rresp_i(rresp),
    .m_axil_rvalid_i(rvalid),
    .m_axil_rready_o(rready),
    .error_o(error_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset_i) begin
      if (awvalid && awready) aw_cnt++;
      if (wvalid && wready)   w_cnt++;
      if (bvalid && bready)   b_cnt++;
      if (arvalid && arready) ar_cnt++;
      if (rvalid && rready)   r_cnt++;
      if (v_o)                vo_hi_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    v_i = 0; data_i = '0; ready_i = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 1;
    tick(); tick();
    reset_i = 0;
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
    n_cmp++; if ({awvalid, wvalid, arvalid, bready, rready, v_o} !== 6'b0) begin n_err++;
      $display("FAIL reset_valids: got %b expected 000000", {awvalid, wvalid, arvalid, bready, rready, v_o}); end
    n_cmp++; if (data_o !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h expected 00000000", data_o); end
    n_cmp++; if (error_o !== 1'b0) begin n_err++; $display("FAIL reset_error: got %b expected 0", error_o); end
    n_cmp++; if ({awprot, arprot} !== 6'b0) begin n_err++; $display("FAIL reset_prot: got %b expected 000000", {awprot, arprot}); end
  endtask

  task automatic test_write();
    int aw0 = aw_cnt, w0 = w_cnt, b0 = b_cnt, vo0 = vo_hi_cnt;
    data_i = 32'h800102A5; v_i = 1;
    n_cmp++; if ({ready_o, awvalid, wvalid} !== 3'b100) begin n_err++;
      $display("FAIL wr_accept: got ready/aw/w %b expected 100", {ready_o, awvalid, wvalid}); end
    tick();
    v_i = 0; data_i = '0; wready = 1;
    n_cmp++; if ({ready_o, awvalid, wvalid} !== 3'b011) begin n_err++;
      $display("FAIL wr_cycle1: got ready/aw/w %b expected 011", {ready_o, awvalid, wvalid}); end
    n_cmp++; if (awaddr !== 32'h00000102) begin n_err++; $display("FAIL wr_awaddr: got %h expected 00000102", awaddr); end
    n_cmp++; if (wdata !== 32'hA5A5A5A5) begin n_err++; $display("FAIL wr_wdata: got %h expected a5a5a5a5", wdata); end
    n_cmp++; if (wstrb !== 4'b0100) begin n_err++; $display("FAIL wr_wstrb: got %b expected 0100", wstrb); end
    tick();
    wready = 0;
    n_cmp++; if ({awvalid, wvalid} !== 2'b10) begin n_err++; $display("FAIL wr_cycle2: got aw/w %b expected 10", {awvalid, wvalid}); end
    tick();
    awready = 1;
    n_cmp++; if ({awvalid, wvalid, bready} !== 3'b100) begin n_err++;
      $display("FAIL wr_cycle3: got aw/w/b %b expected 100", {awvalid, wvalid, bready}); end
    n_cmp++; if (awaddr !== 32'h00000102) begin n_err++; $display("FAIL wr_awaddr_hold: got %h expected 00000102", awaddr); end
    tick();
    awready = 0;
    n_cmp++; if ({awvalid, wvalid, bready} !== 3'b001) begin n_err++;
      $display("FAIL wr_bwait: got aw/w/b %b expected 001", {awvalid, wvalid, bready}); end
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0;
    n_cmp++; if ({ready_o, error_o, bready} !== 3'b100) begin n_err++;
      $display("FAIL wr_done: got ready/err/b %b expected 100", {ready_o, error_o, bready}); end
    n_cmp++; if ({aw_cnt - aw0, w_cnt - w0, b_cnt - b0, vo_hi_cnt - vo0} !== {32'd1, 32'd1, 32'd1, 32'd0}) begin n_err++;
      $display("FAIL wr_counts: got aw=%0d w=%0d b=%0d vo=%0d expected 1 1 1 0", aw_cnt - aw0, w_cnt - w0, b_cnt - b0, vo_hi_cnt - vo0); end
  endtask

  task automatic test_read();
    int ar0 = ar_cnt, r0 = r_cnt;
    data_i = 32'h00000700; v_i = 1;
    tick();
    v_i = 0; data_i = '0;
    n_cmp++; if ({arvalid, awvalid, wvalid} !== 3'b100) begin n_err++;
      $display("FAIL rd_arvalid: got ar/aw/w %b expected 100", {arvalid, awvalid, wvalid}); end
    n_cmp++; if (araddr !== 32'h00000007) begin n_err++; $display("FAIL rd_araddr: got %h expected 00000007", araddr); end
    arready = 1;
    tick();
    arready = 0;
    n_cmp++; if ({arvalid, rready} !== 2'b01) begin n_err++; $display("FAIL rd_rwait: got ar/r %b expected 01", {arvalid, rready}); end
    rvalid = 1; rdata = 32'hDEADBEEF; rresp = 2'b00;
    tick();
    rvalid = 0; rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({v_o, data_o} !== {1'b1, 32'h000000DE}) begin n_err++;
        $display("FAIL rd_hold%0d: got v=%b data=%h expected v=1 data=000000de", i, v_o, data_o); end
      tick();
    end
    ready_i = 1;
    n_cmp++; if ({v_o, data_o} !== {1'b1, 32'h000000DE}) begin n_err++;
      $display("FAIL rd_return: got v=%b data=%h expected v=1 data=000000de", v_o, data_o); end
    tick();
    ready_i = 0;
    n_cmp++; if ({v_o, ready_o, error_o} !== 3'b010) begin n_err++;
      $display("FAIL rd_done: got v/ready/err %b expected 010", {v_o, ready_o, error_o}); end
    n_cmp++; if ({ar_cnt - ar0, r_cnt - r0} !== {32'd1, 32'd1}) begin n_err++;
      $display("FAIL rd_counts: got ar=%0d r=%0d expected 1 1", ar_cnt - ar0, r_cnt - r0); end
  endtask

  task automatic test_simultaneous();
    int aw0 = aw_cnt, w0 = w_cnt;
    data_i = 32'h80000311; v_i = 1;
    tick();
    v_i = 0; data_i = '0; awready = 1; wready = 1;
    n_cmp++; if ({awvalid, wvalid} !== 2'b11) begin n_err++; $display("FAIL sim_valids: got aw/w %b expected 11", {awvalid, wvalid}); end
    n_cmp++; if ({awaddr, wdata, wstrb} !== {32'h00000003, 32'h11111111, 4'b1000}) begin n_err++;
      $display("FAIL sim_payload: got addr=%h data=%h strb=%b expected 00000003 11111111 1000", awaddr, wdata, wstrb); end
    tick();
    n_cmp++; if ({awvalid, wvalid, bready} !== 3'b001) begin n_err++;
      $display("FAIL sim_resp: got aw/w/b %b expected 001", {awvalid, wvalid, bready}); end
    tick();
    n_cmp++; if ({awvalid, wvalid, bready} !== 3'b001) begin n_err++;
      $display("FAIL sim_nodup: got aw/w/b %b expected 001", {awvalid, wvalid, bready}); end
    bvalid = 1;
    tick();
    bvalid = 0; awready = 0; wready = 0;
    n_cmp++; if ({aw_cnt - aw0, w_cnt - w0} !== {32'd1, 32'd1}) begin n_err++;
      $display("FAIL sim_counts: got aw=%0d w=%0d expected 1 1", aw_cnt - aw0, w_cnt - w0); end
  endtask

  task automatic test_errors();
    data_i = 32'h80000042; v_i = 1;
    tick();
    v_i = 0; data_i = '0; awready = 1; wready = 1;
    n_cmp++; if (wstrb !== 4'b0001) begin n_err++; $display("FAIL err_wstrb: got %b expected 0001", wstrb); end
    tick();
    awready = 0; wready = 0; bvalid = 1; bresp = 2'b10;
    n_cmp++; if (error_o !== 1'b0) begin n_err++; $display("FAIL err_before_b: got %b expected 0", error_o); end
    tick();
    bvalid = 0; bresp = 2'b00;
    n_cmp++; if (error_o !== 1'b1) begin n_err++; $display("FAIL err_after_b: got %b expected 1", error_o); end
    data_i = 32'h00000100; v_i = 1;
    tick();
    v_i = 0; data_i = '0; arready = 1;
    tick();
    arready = 0; rvalid = 1; rdata = 32'h12345678; rresp = 2'b00;
    tick();
    rvalid = 0; rdata = '0;
    n_cmp++; if ({v_o, data_o, error_o} !== {1'b1, 32'h00000056, 1'b1}) begin n_err++;
      $display("FAIL err_read: got v=%b data=%h err=%b expected v=1 data=00000056 err=1", v_o, data_o, error_o); end
    ready_i = 1;
    tick();
    ready_i = 0;
    n_cmp++; if (error_o !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b expected 1", error_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] cmds[4];
    int idx = 0;
    int aw0 = aw_cnt, w0 = w_cnt, b0 = b_cnt, ar0 = ar_cnt, r0 = r_cnt;
    cmds[0] = 32'h800000AB; cmds[1] = 32'h00000100;
    cmds[2] = 32'h800003CD; cmds[3] = 32'h00000200;
    exp_q.delete();
    exp_q.push_back(32'h000000F0);
    exp_q.push_back(32'h000000FE);
    awready = 1; wready = 1; bvalid = 1; arready = 1; rvalid = 1; ready_i = 1;
    rdata = 32'hCAFEF00D;
    for (int c = 0; c < 15; c++) begin
      v_i    = (idx < 4);
      data_i = (idx < 4) ? cmds[idx] : 32'h0;
      n_cmp++; if (ready_o !== (c == 0 || c == 3 || c == 7 || c == 10 || c == 14)) begin n_err++;
        $display("FAIL b2b_ready_c%0d: got %b expected %b", c, ready_o, (c == 0 || c == 3 || c == 7 || c == 10 || c == 14)); end
      n_cmp++; if (v_o !== (c == 6 || c == 13)) begin n_err++;
        $display("FAIL b2b_vo_c%0d: got %b expected %b", c, v_o, (c == 6 || c == 13)); end
      if (v_o && ready_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_extra: got data=%h expected no response", data_o); end
        else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (data_o !== e) begin n_err++; $display("FAIL b2b_data: got %h expected %h", data_o, e); end
        end
      end
      if (v_i && ready_o) idx++;
      tick();
    end
    idle_inputs();
    n_cmp++; if ({idx, exp_q.size()} !== {32'd4, 32'd0}) begin n_err++;
      $display("FAIL b2b_progress: got accepted=%0d pending=%0d expected 4 0", idx, exp_q.size()); end
    n_cmp++; if ({aw_cnt - aw0, w_cnt - w0, b_cnt - b0, ar_cnt - ar0, r_cnt - r0} !== {32'd2, 32'd2, 32'd2, 32'd2, 32'd2}) begin n_err++;
      $display("FAIL b2b_counts: got aw=%0d w=%0d b=%0d ar=%0d r=%0d expected 2 each",
               aw_cnt - aw0, w_cnt - w0, b_cnt - b0, ar_cnt - ar0, r_cnt - r0); end
  endtask

  task automatic test_reset_mid();
    data_i = 32'h00000500; v_i = 1;
    tick();
    v_i = 0; data_i = '0; arready = 1;
    tick();
    arready = 0;
    n_cmp++; if (rready !== 1'b1) begin n_err++; $display("FAIL rst_mid_rready: got %b expected 1", rready); end
    reset_i = 1;
    tick();
    reset_i = 0;
    n_cmp++; if ({awvalid, wvalid, arvalid, bready, rready, v_o} !== 6'b0) begin n_err++;
      $display("FAIL rst_mid_valids: got %b expected 000000", {awvalid, wvalid, arvalid, bready, rready, v_o}); end
    n_cmp++; if ({ready_o, error_o} !== 2'b10) begin n_err++;
      $display("FAIL rst_mid_state: got ready/err %b expected 10", {ready_o, error_o}); end
  endtask

  initial begin
    reset_i = 1;
    idle_inputs();
    test_reset();
    test_write();
    test_read();
    test_simultaneous();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
